// File: rtl/exp_pkg.sv
// Shared widths and FSM state encodings for the exponent engine and its multiplier.
package exp_pkg;
  localparam int W_OP        = 8;
  localparam int W_RES       = 16;
  localparam int W_PROD      = W_RES + W_OP;
  localparam int MUL_STEPS   = 8;
  localparam int ITER_CYCLES = MUL_STEPS + 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] MUL    = 3'd2;
  localparam logic [2:0] ACC    = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;
endpackage

// File: rtl/exp_mul16x8.sv
// Sequential LSB-first shift-add multiplier, 16x8 -> 24 bits, one step per cycle.
module exp_mul16x8
  import exp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [W_RES-1:0]  mcand_i,
  input  logic [W_OP-1:0]   mplier_i,
  output logic [W_PROD-1:0] prod_o,
  output logic              rdy_o
);
  logic [W_PROD-1:0] mcand_q, prod_q;
  logic [W_OP-1:0]   mplier_q;
  logic [3:0]        step_q;
  logic              run_q, rdy_q;

  // The go cycle performs step 1, so rdy lands exactly 8 steps after go.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      run_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (go_i) begin
        mcand_q  <= W_PROD'(mcand_i) << 1;
        mplier_q <= mplier_i >> 1;
        prod_q   <= mplier_i[0] ? W_PROD'(mcand_i) : '0;
        step_q   <= 4'd1;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        step_q   <= step_q + 4'd1;
        if (step_q == 4'(MUL_STEPS - 1)) begin
          run_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      end
    end
  end

  assign prod_o = prod_q;
  assign rdy_o  = rdy_q;
endmodule

// File: rtl/exp_fsmd_core.sv
// Exponent engine: res = a^n (truncated to W_RES) by repeated shift-add multiplies.
module exp_fsmd_core
  import exp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_OP-1:0]  a_in,
  input  logic [W_OP-1:0]  n_in,
  output logic [W_OP-1:0]  a_out,
  output logic [W_OP-1:0]  n_out,
  output logic [W_RES-1:0] res,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             done_pulse
);
  state_t            state_q, state_d;
  logic [W_OP-1:0]   a_q, n_q, cnt_q, cnt_dec;
  logic [W_RES-1:0]  res_q, mcand;
  logic              ovf_q, busy_q, done_q, dp_q;
  logic              go, mul_rdy;
  logic [W_PROD-1:0] prod;

  assign cnt_dec = cnt_q - {{(W_OP-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    mcand   = res_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD: begin
        if (cnt_q == '0) state_d = FINISH;
        else begin
          go      = 1'b1;
          state_d = MUL;
        end
      end
      MUL:    if (mul_rdy) state_d = ACC;
      ACC: begin
        // Next multiply must use the product being committed this cycle.
        mcand = prod[W_RES-1:0];
        if (cnt_dec == '0) state_d = FINISH;
        else begin
          go      = 1'b1;
          state_d = MUL;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dp_q    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q    <= a_in;
          n_q    <= n_in;
          cnt_q  <= n_in;
          res_q  <= {{(W_RES-1){1'b0}}, 1'b1};
          ovf_q  <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b1;
        end
        ACC: begin
          res_q <= prod[W_RES-1:0];
          ovf_q <= ovf_q | (|prod[W_PROD-1:W_RES]);
          cnt_q <= cnt_dec;
        end
        FINISH: begin
          done_q <= 1'b1;
          dp_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  exp_mul16x8 u_mul (
    .clk      (clk),
    .rst      (rst),
    .go_i     (go),
    .mcand_i  (mcand),
    .mplier_i (a_q),
    .prod_o   (prod),
    .rdy_o    (mul_rdy)
  );

  assign a_out      = a_q;
  assign n_out      = n_q;
  assign res        = res_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_pulse = dp_q;
endmodule

// File: tb/tb_exp_fsmd_core.sv
// Directed bench for exp_fsmd_core: hand-computed powers, latency, ignore-while-busy, async reset.
module tb_exp_fsmd_core;
  logic        clk, rst, start;
  logic [7:0]  a_in, n_in, a_out, n_out;
  logic [15:0] res;
  logic        overflow, busy, done, done_pulse;

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, pulses = 0;

  exp_fsmd_core dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .n_in(n_in),
    .a_out(a_out), .n_out(n_out), .res(res), .overflow(overflow),
    .busy(busy), .done(done), .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done_pulse) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one sampling edge; t0 marks that edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] n);
    @(negedge clk);
    a_in = a; n_in = n; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_res,
                           input logic exp_ovf, input logic [7:0] exp_a, input logic [7:0] exp_n);
    bit got = 0;
    int p0 = pulses;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if (done_pulse) got = 1;
    end
    chk({tag, "_lat"}, got ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, "_res"}, 32'(res), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_aout"}, 32'(a_out), 32'(exp_a));
    chk({tag, "_nout"}, 32'(n_out), 32'(exp_n));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_dp_clr"}, 32'(done_pulse), 32'd0);
    chk({tag, "_done_lvl"}, 32'(done), 32'd1);
    chk({tag, "_npulse"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a_in = '0; n_in = '0;
    #2;
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_flags", {28'd0, overflow, busy, done, done_pulse}, 32'd0);
    chk("rst_ops", {16'd0, a_out, n_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    launch(8'd3, 8'd4);
    chk("b34_busy", 32'(busy), 32'd1);
    chk("b34_done_clr", 32'(done), 32'd0);
    wait_done("a3n4", 38, 16'h0051, 1'b0, 8'd3, 8'd4);

    launch(8'd2, 8'd15);
    wait_done("a2n15", 2 + 9*15, 16'h8000, 1'b0, 8'd2, 8'd15);
    launch(8'd2, 8'd16);
    wait_done("a2n16", 2 + 9*16, 16'h0000, 1'b1, 8'd2, 8'd16);

    launch(8'hFF, 8'd2);
    wait_done("aFFn2", 20, 16'hFE01, 1'b0, 8'hFF, 8'd2);
    launch(8'hFF, 8'd3);
    wait_done("aFFn3", 29, 16'h02FF, 1'b1, 8'hFF, 8'd3);

    launch(8'h00, 8'd0);
    wait_done("a0n0", 2, 16'h0001, 1'b0, 8'h00, 8'd0);
    launch(8'h7A, 8'd0);
    wait_done("a7An0", 2, 16'h0001, 1'b0, 8'h7A, 8'd0);
    launch(8'h00, 8'd5);
    wait_done("a0n5", 47, 16'h0000, 1'b0, 8'h00, 8'd5);

    // Second request while busy must be ignored entirely.
    launch(8'd3, 8'd4);
    repeat (10) @(posedge clk);
    @(negedge clk) begin a_in = 8'd5; n_in = 8'd2; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    chk("ign_aout", 32'(a_out), 32'd3);
    chk("ign_nout", 32'(n_out), 32'd4);
    wait_done("ign", 38, 16'h0051, 1'b0, 8'd3, 8'd4);

    // Asynchronous reset in the middle of a multiply.
    begin
      int p0;
      p0 = pulses;
      launch(8'd3, 8'd4);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_res", 32'(res), 32'd0);
      chk("arst_ops", {16'd0, a_out, n_out}, 32'd0);
      chk("arst_flags", {28'd0, overflow, busy, done, done_pulse}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("arst_nopulse", 32'(pulses - p0), 32'd0);
      chk("arst_idle", {30'd0, busy, done}, 32'd0);
    end
    launch(8'd5, 8'd3);
    wait_done("post_rst", 29, 16'd125, 1'b0, 8'd5, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
